// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed MULT/DIV unit that fills the HI/LO registers of a
//   multicycle MIPS datapath. The control unit starts an operation with
//   start/op and watches busy/done. Multiply uses radix-2 Booth recoding.
//   Divide is a restoring divide on the operand magnitudes, followed by a
//   sign fix-up cycle. Both retire one iteration per clock.
//
// Ports
//   clock     in   1      rising-edge clock
//   reset     in   1      asynchronous reset, active low
//   start     in   1      request, sampled only while idle
//   op        in   1      0 = MULT, 1 = DIV
//   a_in      in   WIDTH  multiplicand / dividend (two's complement)
//   b_in      in   WIDTH  multiplier / divisor (two's complement)
//   busy      out  1      operation in progress (MULT, DIV, FIX)
//   done      out  1      one-cycle completion pulse
//   div_zero  out  1      last DIV had a zero divisor; sticky until next start
//   hi_out    out  WIDTH  product high half / remainder
//   lo_out    out  WIDTH  product low half / quotient
// ----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    // Shared datapath registers.
    //   MULT: acc = Booth accumulator (one guard bit), qr = multiplier,
    //         m = multiplicand, qm1 = Booth look-behind bit.
    //   DIV : acc = partial remainder, qr = |dividend| shifting into quotient,
    //         m = |divisor|.
    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH:0]   acc_q,    acc_d;
    logic [WIDTH-1:0] qr_q,     qr_d;
    logic [WIDTH-1:0] m_q,      m_d;
    logic             qm1_q,    qm1_d;
    logic             a_neg_q,  a_neg_d;
    logic             b_neg_q,  b_neg_d;
    logic             dz_q,     dz_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;

    // Iteration helpers
    logic             last_step;
    logic [WIDTH:0]   m_sext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] rem_diff;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so that no
        // path through the case statement leaves one unassigned (a latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        last_step = (cnt_q == CW'(WIDTH - 1));
        a_abs     = a_in[WIDTH-1] ? -a_in : a_in;
        b_abs     = b_in[WIDTH-1] ? -b_in : b_in;

        // Booth step: add/subtract the multiplicand based on the bit pair
        // {qr[0], qm1}. The extra accumulator bit absorbs the overflow of
        // adding or subtracting the most-negative multiplicand.
        m_sext = {m_q[WIDTH-1], m_q};
        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_sext;
            2'b10:   booth_sum = acc_q - m_sext;
            default: booth_sum = acc_q;
        endcase

        // Restoring step: shift the next dividend bit into the remainder and
        // trial-subtract the divisor. The remainder can reach 2*|b|-1, so the
        // trial result is one bit wider again to expose the borrow.
        rem_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, m_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    a_neg_d = a_in[WIDTH-1];
                    b_neg_d = b_in[WIDTH-1];
                    if (op) begin
                        qr_d    = a_abs;
                        m_d     = b_abs;
                        state_d = S_DIV;
                    end else begin
                        qr_d    = b_in;
                        m_d     = a_in;
                        state_d = S_MULT;
                    end
                end
            end

            S_MULT: begin
                // Arithmetic shift right of {acc, qr, qm1} after the add.
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                qr_d  = {booth_sum[0], qr_q[WIDTH-1:1]};
                qm1_d = qr_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    // The product fits in 2*WIDTH bits, so the guard bit is
                    // only a sign copy and can be dropped.
                    hi_d    = booth_sum[WIDTH:1];
                    lo_d    = {booth_sum[0], qr_q[WIDTH-1:1]};
                    state_d = S_DONE;
                end
            end

            S_DIV: begin
                if (cnt_q == '0 && m_q == '0) begin
                    // Zero divisor: leave HI/LO untouched and raise the flag.
                    dz_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    if (!rem_diff[WIDTH+1]) begin
                        acc_d = rem_diff[WIDTH:0];
                        qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift;
                        qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        state_d = S_FIX;
                    end
                end
            end

            S_FIX: begin
                // The quotient is negative when the operand signs differ.
                // The remainder takes the sign of the dividend. The
                // most-negative / -1 case wraps naturally: magnitude 2^(W-1)
                // with no negation yields the same bit pattern.
                lo_d    = (a_neg_q ^ b_neg_q) ? -qr_q : qr_q;
                hi_d    = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // values from before this edge, whatever the statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. Expected HI/LO values come from
//   plain 64-bit signed arithmetic (*, /, %), not from the iteration
//   algorithms. Each operation also checks latency, busy, the single-cycle
//   done pulse and the sticky div_zero flag.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation, from ordinary signed arithmetic.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p      = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
        end else if (b == '0) begin
            exp_dz = 1'b1;
        end else begin
            q      = sa / sb;
            r      = sa % sb;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_dz = 1'b0;
        end
    endtask

    // Issue one operation and follow it to completion. If poke_done is set,
    // a start pulse is also driven during the done cycle; it must be ignored.
    task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke_done);
        int           n;
        int           exp_lat;
        bit           busy_ok;
        bit           hold_ok;
        logic [W-1:0] prev_hi;
        logic [W-1:0] prev_lo;

        @(negedge clock);
        check({tag, ".dz_pre"}, 64'(div_zero), 64'(exp_dz));
        prev_hi = hi_out;
        prev_lo = lo_out;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(negedge clock);                 // accepting edge E0 has passed
        start = 1'b0;
        a_in  = $urandom;                 // operands must already be latched
        b_in  = $urandom;
        model(o, a, b);
        exp_lat = !o ? W : (b == '0 ? 1 : W + 1);
        check({tag, ".dz_start"}, 64'(div_zero), 64'(0));

        n       = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (hi_out !== prev_hi || lo_out !== prev_lo) hold_ok = 1'b0;
            @(negedge clock);
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".busy_run"}, 64'(busy_ok), 64'(1));
        check({tag, ".hold"}, 64'(hold_ok), 64'(1));
        check({tag, ".busy_done"}, 64'(busy), 64'(0));
        check({tag, ".hi"}, 64'(hi_out), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo_out), 64'(exp_lo));
        check({tag, ".dz"}, 64'(div_zero), 64'(exp_dz));

        if (poke_done) begin
            start = 1'b1;
            op    = 1'b0;
            a_in  = 32'd3;
            b_in  = 32'd3;
        end
        @(negedge clock);
        start = 1'b0;
        check({tag, ".done_pulse"}, 64'(done), 64'(0));
        check({tag, ".idle"}, 64'(busy), 64'(0));
        if (poke_done) begin
            @(negedge clock);
            check({tag, ".ign_busy"}, 64'(busy), 64'(0));
            check({tag, ".ign_lo"}, 64'(lo_out), 64'(exp_lo));
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h8000_0000;
            1:       v = 32'h7FFF_FFFF;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'd1;
            4:       v = 32'd0;
            5:       v = $urandom_range(0, 1000);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin : stim
        int           n;
        bit           saw_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ro;

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.dz", 64'(div_zero), 64'(0));
        check("rst.hi", 64'(hi_out), 64'(0));
        check("rst.lo", 64'(lo_out), 64'(0));
        reset = 1'b1;

        // Directed cases
        run_op("t1_mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("t2_mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        run_op("t3_div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("t4_div_wrap", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("t5_mul_2x3", 1'b0, 32'd2, 32'd3, 1'b0);
        run_op("t5_div_by0", 1'b1, 32'd5, 32'd0, 1'b1);
        run_op("t5_mul_clr", 1'b0, 32'd9, 32'hFFFF_FFF6, 1'b0);
        run_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_small", 1'b1, 32'd3, 32'd10, 1'b0);

        // A restart during MULT must be ignored
        @(negedge clock);
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd11;
        b_in  = 32'd13;
        @(negedge clock);
        start = 1'b0;
        model(1'b0, 32'd11, 32'd13);
        repeat (4) @(negedge clock);
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd0;
        @(negedge clock);
        start = 1'b0;
        n = 5;
        while (!done && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("t6_restart.latency", 64'(n), 64'(W));
        check("t6_restart.lo", 64'(lo_out), 64'(exp_lo));
        check("t6_restart.hi", 64'(hi_out), 64'(exp_hi));
        check("t6_restart.dz", 64'(div_zero), 64'(0));
        @(negedge clock);

        // Reset in the middle of a MULT aborts it and clears the results
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd9;
        b_in  = 32'd9;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_rst.busy", 64'(busy), 64'(0));
        check("t6_rst.done", 64'(done), 64'(0));
        check("t6_rst.hi", 64'(hi_out), 64'(0));
        check("t6_rst.lo", 64'(lo_out), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        check("t6_rst.no_done", 64'(saw_done), 64'(0));
        run_op("t6_mul_4x5", 1'b0, 32'd4, 32'd5, 1'b0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
            run_op(ro ? "rand_div" : "rand_mul", ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
